sw_input_conditioner: RTL
=========================

# sw_input_conditioner

Input-side counterpart to the LED output path: it takes the raw board switches and turns them into clean, clock-synchronous control signals. The block synchronises and debounces each switch, then emits per-switch rising and falling edge pulses. It sits between the board pins and the rate counter and shift register, replacing their direct use of raw switch levels. Mode changes become single-cycle events.

## Interface
Parameters:
- `NB_SW`, 4, number of switch inputs.
- `DB_COUNT`, 1000000, debounce length in clock cycles (10 ms at 100 MHz); legal range is ≥ 1.
- `NB_CNT`, 20, debounce counter width; `DB_COUNT` must be < 2^`NB_CNT`.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_sw`  in  `NB_SW`  raw, asynchronous switch levels.
- `o_sw`  out  `NB_SW`  debounced switch levels.
- `o_rise`  out  `NB_SW`  one-cycle pulse when `o_sw[i]` goes 0→1.
- `o_fall`  out  `NB_SW`  one-cycle pulse when `o_sw[i]` goes 1→0.
- `o_change`  out  1  OR-reduction of `o_rise | o_fall`, registered together with them.

## Operation
- **Reset values.** On `i_reset` every flop clears immediately: the sync flops, counters, and states (STABLE). `o_sw`, `o_rise`, `o_fall` and `o_change` are all 0.
- **Synchroniser.** Each bit passes through a 2-flop synchroniser, `sync0` then `sync1`. Only `sync1` is used downstream.
- **Per-bit FSM, two states:**
  - **STABLE.** If `sync1 != o_sw[i]`: go to COUNTING and set cnt = 1. Otherwise stay, with cnt = 0.
  - **COUNTING, mismatch gone.** If `sync1 == o_sw[i]`: this is a glitch, so return to STABLE, set cnt = 0, and leave `o_sw` unchanged.
  - **COUNTING, still mismatched.** If `sync1 != o_sw[i]` and cnt < `DB_COUNT`: set cnt = cnt + 1.
  - **Accept.** If `sync1 != o_sw[i]` and cnt == `DB_COUNT`: set `o_sw[i]` to `sync1`, pulse `o_rise[i]` or `o_fall[i]` per the new value, go to STABLE, set cnt = 0.
- **Acceptance rule.** A new level is accepted only after `DB_COUNT`+1 consecutive mismatching `sync1` samples. Any shorter excursion is discarded with no output activity.
- **Counter width.** cnt never exceeds `DB_COUNT`, so there is no wrap-around. The counter is `NB_CNT` bits, unsigned.
- **Independence.** Bits are fully independent. Simultaneous acceptances on several bits assert their pulses in the same cycle, with `o_change` = 1 for one cycle.
- **Pulse width.** Pulses are exactly one cycle wide. Consecutive accepted edges on the same bit are spaced at least `DB_COUNT`+1 cycles apart.
- **Reset mid-count.** Asserting reset during a count aborts it and returns the bit to STABLE with `o_sw` = 0.
- **Switch held high through reset.** After reset release, the bit goes through a normal debounce and produces `o_rise`.

## Timing
- **Latency.** From a clean `i_sw` change to the `o_sw` update and edge pulse: `DB_COUNT` + 3 clock edges. That is 2 edges of synchroniser and `DB_COUNT`+1 edges of counting.
- **Output registration.** All outputs are registered, with no combinational path from `i_sw`. `o_rise`, `o_fall` and `o_change` assert on the same edge that `o_sw` updates.
- **Reset assertion.** Asynchronous: outputs clear without waiting for a clock edge.
- **Reset release.** The first functional edge is the first rising `clock` edge after `i_reset` falls.

## Structure
- **Shared package.** Holds the FSM state encoding constants (ST_STABLE = 1'b0, ST_COUNTING = 1'b1) and the default `DB_COUNT` / `NB_CNT` values. These are reused by the rate counter when it moves to edge-triggered mode selection.
- **Sub-module.** `sw_debounce_bit` implements the synchroniser, counter, FSM and edge pulses for one bit, parameterised by `DB_COUNT` and `NB_CNT`. It is instantiated `NB_SW` times with a generate loop.
- **Top level.** The top does only the generate loop and the `o_change` OR-reduction register.

## Test plan
All benches override `DB_COUNT` = 4 and `NB_CNT` = 3.
- **Reset values.** Assert `i_reset` with `i_sw` = 4'b1111 → all outputs are 0 immediately, without waiting for a clock edge.
- **Clean rise.** Release reset with `i_sw` = 4'b0000, then drive `i_sw[0]` 0→1 and hold → `o_sw[0]` = 1 exactly 7 edges later. `o_rise[0]` and `o_change` are high for exactly 1 cycle, and `o_fall` stays 0.
- **Glitch rejection and acceptance.**
  - Pulse `i_sw[1]` high for 4 cycles → `o_sw[1]` stays 0, with no pulses.
  - Pulse `i_sw[1]` high for 5 cycles → `o_sw[1]` = 1 after 7 edges. It returns to 0 with an `o_fall[1]` pulse 7 edges after the input falls.
- **Bounce train.** Toggle `i_sw[2]` every cycle for 20 cycles, then hold it at 1 → exactly one `o_rise[2]`, 7 edges after the final transition.
- **Simultaneous edges.** Change `i_sw[3:2]` from 2'b00 to 2'b11 in the same cycle → `o_rise` = 4'b1100 in a single cycle, with `o_change` = 1 for one cycle.
- **Reset mid-count.** Drive `i_sw[0]` = 1 and assert `i_reset` after 3 edges → `o_sw` stays 0. After release with the input still high, `o_rise[0]` fires 7 edges later.

Source files
------------

// File: rtl/sw_input_conditioner_pkg.sv
// rtl/sw_input_conditioner_pkg.sv - shared debounce state encoding and default timing values
package sw_input_conditioner_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_t;

    localparam int DEF_DB_COUNT = 1000000;
    localparam int DEF_NB_CNT   = 20;

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - single-switch synchroniser, debounce counter and edge pulses
module sw_debounce_bit
    import sw_input_conditioner_pkg::*;
#(
    parameter int DB_COUNT = DEF_DB_COUNT,
    parameter int NB_CNT   = DEF_NB_CNT
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_edge
);

    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(DB_COUNT);

    logic              sync0;
    logic              sync1;
    db_state_t         state;
    logic [NB_CNT-1:0] cnt;
    logic              mismatch;

    assign mismatch = (sync1 != o_sw);

    // Unregistered accept strobe so the top can register o_change on the same edge as the pulses.
    assign o_edge = (state == ST_COUNTING) && mismatch && (cnt == CNT_MAX);

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            state  <= ST_STABLE;
            cnt    <= '0;
            o_sw   <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync0  <= i_sw;
            sync1  <= sync0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (mismatch) begin
                        state <= ST_COUNTING;
                        cnt   <= NB_CNT'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_COUNTING: begin
                    if (!mismatch) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        o_sw   <= sync1;
                        o_rise <= sync1;
                        o_fall <= ~sync1;
                        state  <= ST_STABLE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sw_input_conditioner.sv
// rtl/sw_input_conditioner.sv - per-switch debounce array with combined change strobe
module sw_input_conditioner
    import sw_input_conditioner_pkg::*;
#(
    parameter int NB_SW    = 4,
    parameter int DB_COUNT = DEF_DB_COUNT,
    parameter int NB_CNT   = DEF_NB_CNT
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_rise,
    output logic [NB_SW-1:0] o_fall,
    output logic             o_change
);

    logic [NB_SW-1:0] edge_now;

    for (genvar i = 0; i < NB_SW; i++) begin : g_bit
        sw_debounce_bit #(
            .DB_COUNT (DB_COUNT),
            .NB_CNT   (NB_CNT)
        ) u_bit (
            .clock   (clock),
            .i_reset (i_reset),
            .i_sw    (i_sw[i]),
            .o_sw    (o_sw[i]),
            .o_rise  (o_rise[i]),
            .o_fall  (o_fall[i]),
            .o_edge  (edge_now[i])
        );
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_change <= 1'b0;
        end else begin
            o_change <= |edge_now;
        end
    end

endmodule
